// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-organised SRAM: pipelined address/data phases,
// optional wait states, byte/halfword/word writes and the two-cycle ERROR response.
module ahb_sram_subordinate #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [1:0]            state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    logic [31:0]           offset;
    logic                  in_range;
    logic                  aligned;
    logic                  legal;
    logic                  accept;
    logic                  phase_done;
    logic                  a_valid;
    logic                  a_write;
    logic [2:0]            a_size;
    logic [1:0]            a_lane;
    logic [AW-1:0]         a_index;
    logic [3:0]            wait_cnt;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic                  unused_htrans;

    assign unused_htrans = HTRANS[0];

    // Handshake: a transfer is accepted at a rising edge where HSEL, HREADY and HTRANS[1] are
    // all high; its data phase ends at the first later rising edge where HREADYOUT is high.
    assign accept = HSEL & HREADY & HTRANS[1];

    assign offset   = HADDR - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;

    always_comb begin
        aligned = 1'b0;
        case (HSIZE)
            3'b000:  aligned = 1'b1;
            3'b001:  aligned = ~HADDR[0];
            3'b010:  aligned = (HADDR[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign legal      = in_range & aligned;
    assign HREADYOUT  = (state == ST_IDLE) || (state == ST_ERR2);
    assign HRESP      = (state == ST_ERR1) || (state == ST_ERR2);
    // a_valid is only ever set for OKAY transfers, so erroring ones never commit.
    assign phase_done = a_valid & HREADYOUT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            a_valid  <= 1'b0;
            a_write  <= 1'b0;
            a_size   <= 3'd0;
            a_lane   <= 2'd0;
            a_index  <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= ST_IDLE;
                end
                ST_ERR1: state <= ST_ERR2;
                default: begin
                    a_valid <= 1'b0;
                    state   <= ST_IDLE;
                    if (accept) begin
                        a_write <= HWRITE;
                        a_size  <= HSIZE;
                        a_lane  <= HADDR[1:0];
                        a_index <= offset[AW+1:2];
                        if (!legal) begin
                            state <= ST_ERR1;
                        end else begin
                            a_valid <= 1'b1;
                            if (WAIT_STATES != 0) begin
                                state    <= ST_WAIT;
                                wait_cnt <= WAIT_LOAD;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        case (a_size)
            3'b000:  byte_en = 4'b0001 << a_lane;
            3'b001:  byte_en = a_lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (phase_done && a_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[a_index][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    // Combinational read sees a write committed on the edge that opened this read phase.
    assign HRDATA = (a_valid && !a_write) ? mem[a_index] : '0;

endmodule
